systolic_input_skew_unit: RTL and testbench
===========================================

// Module: systolic_input_skew_unit
// PURPOSE
//   Sits between the unified buffer RAM read port and the west edge of the systolic MAC array.
//   Takes one 32-lane input row per cycle from the unified buffer.
//   Applies the diagonal skew the array needs: lane k is delayed k cycles.
//   Tracks per-lane validity, zero-fills idle lanes, and reports when the last skewed row has drained.
// PARAMETERS
//   MATRIX_DIM   32  rows/lanes per tile; array edge length
//   DATA_W       8   bits per input element
//   RD_LATENCY   1   cycles from unified_buffer_read_en_i to unified_buffer_data_i valid (>=1)
// PORTS
//   clk_i                    in   1                  single clock, rising edge
//   rst_i                    in   1                  synchronous, active-high reset
//   unified_buffer_read_en_i in   1                  read strobe issued by the UB control unit
//   unified_buffer_data_i    in   MATRIX_DIM*DATA_W  RAM read data; lane k = bits [k*DATA_W +: DATA_W]
//   array_data_o             out  MATRIX_DIM*DATA_W  skewed row to array west edge; same lane packing
//   array_valid_o            out  MATRIX_DIM         per-lane valid; bit k qualifies lane k
//   busy_o                   out  1                  high when state != IDLE
//   drain_done_o             out  1                  1-cycle pulse: last valid element left lane MATRIX_DIM-1
//   rows_streamed_o          out  12                 rows accepted since reset; wraps modulo 4096
// BEHAVIOUR
//   - Reset: synchronous, active-high, overrides every other condition.
//     All outputs go to 0, all delay-line contents go to 0, and the FSM goes to IDLE.
//     Reset asserted mid-stream discards in-flight data; no drain_done_o pulse is issued.
//   - Read-enable alignment: read_en is delayed RD_LATENCY cycles through a valid shift register.
//     The delayed bit is row_valid, and it qualifies unified_buffer_data_i in the same cycle.
//   - Capture stage: row_valid captures the row into stage 0 (registered).
//     When row_valid is low, stage 0 loads all zeros.
//   - Skew: lane k output = stage-0 lane k delayed by a further k cycles; lane 0 has no extra delay.
//     array_valid_o[k] follows the same delay as its data.
//   - Latency: a row whose read_en is at cycle T appears on lane k at cycle T + RD_LATENCY + 1 + k.
//   - Zero fill: any lane with array_valid_o[k]=0 drives array_data_o lane k = 0.
//   - Back-to-back: one row per cycle sustained; no bubbles inserted; no backpressure port.
//   - FSM, states IDLE, STREAM, DRAIN:
//       IDLE   -> STREAM when row_valid=1.
//       STREAM -> DRAIN when row_valid=0; drain_cnt loads MATRIX_DIM-1.
//       DRAIN: drain_cnt decrements each cycle.
//         If row_valid=1, go to STREAM (priority over the count).
//         When drain_cnt==0, go to IDLE and pulse drain_done_o in that same cycle.
//   - drain_done_o timing: the pulse coincides with the first cycle in which array_valid_o == 0
//     after the final row.
//   - Simultaneous events: row_valid=1 in the cycle drain_cnt reaches 0 -> go to STREAM, no pulse.
//   - rows_streamed_o: increments by 1 on each row_valid=1 cycle.
//     Wraps 4095 -> 0 silently.
//   - Arithmetic: drain_cnt is $clog2(MATRIX_DIM) bits, unsigned.
//   - Storage: the triangular delay array holds MATRIX_DIM*(MATRIX_DIM-1)/2 elements.
//     Implement it in flops, not RAM.
// STRUCTURE
//   tpu_package additions: MATRIX_DIM, DATA_W, typedef skew_state_t {IDLE,STREAM,DRAIN}.
//   Sub-module skew_delay_line #(DEPTH, WIDTH): a DEPTH-stage register chain with valid bit.
//     DEPTH=0 is a pass-through.
//     Instantiate once per lane via generate, with DEPTH=k.
//   The top level holds the read-latency pipe, stage 0, FSM, drain counter and row counter.
// TESTING
//   1 Reset mid-stream.
//     Stimulus: read_en high for 10 cycles; rst_i at cycle 5 for 1 cycle.
//     Response: all outputs 0 the next cycle; no drain_done_o; rows_streamed_o=0.
//   2 Single row, lane k data = k+1.
//     Response: lane k valid exactly at T+2+k with value k+1.
//     drain_done_o pulses at T+2+32; busy_o falls at the same edge.
//   3 32 rows back-to-back.
//     Response: array_valid_o all-ones for cycles T+33..T+33; no gaps in any lane.
//     rows_streamed_o=32; exactly one drain_done_o.
//   4 Gap rows: read_en pattern 1,0,1.
//     Response: lane 5 shows row A, zero, row B on consecutive cycles.
//     FSM goes STREAM->DRAIN->STREAM; one drain_done_o after row B only.
//   5 Resume at drain end: new read_en timed so row_valid hits the drain_cnt==0 cycle.
//     Response: FSM goes to STREAM, no pulse.
//   6 Counter wrap: 4097 rows.
//     Response: rows_streamed_o reads 1 at the end.

Source files
------------

// File: rtl/systolic_input_skew_unit_pkg.sv
// Shared sizing and FSM encoding for the systolic input skew unit.
package systolic_input_skew_unit_pkg;

    localparam int MATRIX_DIM = 32;
    localparam int DATA_W     = 8;
    localparam int RD_LATENCY = 1;
    localparam int ROW_CNT_W  = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_t;

endpackage

// File: rtl/systolic_input_skew_unit_delay_line.sv
// DEPTH-stage register chain carrying one lane element plus its valid bit.
// Latency DEPTH cycles (DEPTH=0 is a wire); no backpressure, shifts every cycle.
module skew_delay_line #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk_i ^ rst_i;
            assign vld_o = vld_i;
            assign dat_o = dat_i;
        end else begin : g_chain
            logic [DEPTH-1:0] r_vld;
            logic [WIDTH-1:0] r_dat [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_vld <= '0;
                    for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
                end else begin
                    r_vld[0] <= vld_i;
                    r_dat[0] <= dat_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end

            assign vld_o = r_vld[DEPTH-1];
            assign dat_o = r_dat[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_input_skew_unit.sv
// Diagonally skews unified-buffer rows onto the array west edge: lane k at read_en + RD_LATENCY + 1 + k.
// No backpressure: one row per cycle accepted unconditionally; drain_done_o marks the end of a burst.
module systolic_input_skew_unit
    import systolic_input_skew_unit_pkg::*;
#(
    parameter int MATRIX_DIM = systolic_input_skew_unit_pkg::MATRIX_DIM,
    parameter int DATA_W     = systolic_input_skew_unit_pkg::DATA_W,
    parameter int RD_LATENCY = systolic_input_skew_unit_pkg::RD_LATENCY
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         unified_buffer_read_en_i,
    input  logic [MATRIX_DIM*DATA_W-1:0] unified_buffer_data_i,
    output logic [MATRIX_DIM*DATA_W-1:0] array_data_o,
    output logic [MATRIX_DIM-1:0]        array_valid_o,
    output logic                         busy_o,
    output logic                         drain_done_o,
    output logic [ROW_CNT_W-1:0]         rows_streamed_o
);

    localparam int CNT_W = $clog2(MATRIX_DIM);

    logic [RD_LATENCY-1:0]        r_rd_pipe;
    logic                         w_row_valid;
    logic                         r_s0_vld;
    logic [MATRIX_DIM*DATA_W-1:0] r_s0_dat;
    skew_state_t                  r_state;
    logic [CNT_W-1:0]             r_drain_cnt;
    logic [ROW_CNT_W-1:0]         r_rows;

    // Read strobe delayed to line up with the RAM's read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe[0] <= unified_buffer_read_en_i;
            for (int i = 1; i < RD_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
        end
    end

    assign w_row_valid = r_rd_pipe[RD_LATENCY-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s0_vld <= 1'b0;
            r_s0_dat <= '0;
        end else begin
            r_s0_vld <= w_row_valid;
            r_s0_dat <= w_row_valid ? unified_buffer_data_i : '0;
        end
    end

    for (genvar k = 0; k < MATRIX_DIM; k++) begin : g_lane
        logic              w_vld;
        logic [DATA_W-1:0] w_dat;

        skew_delay_line #(
            .DEPTH (k),
            .WIDTH (DATA_W)
        ) u_dly (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .vld_i (r_s0_vld),
            .dat_i (r_s0_dat[k*DATA_W +: DATA_W]),
            .vld_o (w_vld),
            .dat_o (w_dat)
        );

        assign array_valid_o[k]                 = w_vld;
        assign array_data_o[k*DATA_W +: DATA_W] = w_vld ? w_dat : '0;
    end

    // The drain count spans the time for the last row to walk out of lane MATRIX_DIM-1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_row_valid) r_state <= STREAM;
                end
                STREAM: begin
                    if (!w_row_valid) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= CNT_W'(MATRIX_DIM - 1);
                    end
                end
                DRAIN: begin
                    if (w_row_valid)            r_state     <= STREAM;
                    else if (r_drain_cnt == '0) r_state     <= IDLE;
                    else                        r_drain_cnt <= r_drain_cnt - CNT_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)            r_rows <= '0;
        else if (w_row_valid) r_rows <= r_rows + ROW_CNT_W'(1);
    end

    assign busy_o          = (r_state != IDLE);
    assign drain_done_o    = (r_state == DRAIN) && (r_drain_cnt == '0) && !w_row_valid && !rst_i;
    assign rows_streamed_o = r_rows;

endmodule

// File: tb/tb_systolic_input_skew_unit.sv
// Random and directed stimulus for the skew unit, checked every cycle against a timing-rule model.
module tb_systolic_input_skew_unit;
    import systolic_input_skew_unit_pkg::*;

    localparam int D  = MATRIX_DIM;
    localparam int W  = DATA_W;
    localparam int L  = RD_LATENCY;
    localparam int BW = D * W;
    localparam int NC = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [BW-1:0] din;
    logic [BW-1:0] array_data;
    logic [D-1:0]  array_valid;
    logic          busy;
    logic          drain_done;
    logic [11:0]   rows_streamed;

    always #5 clk = ~clk;

    systolic_input_skew_unit dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .unified_buffer_read_en_i (en),
        .unified_buffer_data_i    (din),
        .array_data_o             (array_data),
        .array_valid_o            (array_valid),
        .busy_o                   (busy),
        .drain_done_o             (drain_done),
        .rows_streamed_o          (rows_streamed)
    );

    bit            en_h  [NC];
    bit            rst_h [NC];
    logic [BW-1:0] dat_h [NC];
    int            exp_rows [NC];
    int            cyc    = -1;
    int            checks = 0;
    int            errors = 0;
    int            pulses = 0;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic bit norst(input int a, input int b);
        for (int i = a; i <= b; i++)
            if (i >= 0 && rst_h[i]) return 1'b0;
        return 1'b1;
    endfunction

    // A row is presented to the unit in cycle v if read_en was high L cycles earlier and no reset cut it off.
    function automatic bit rowvalid(input int v);
        if (v - L < 0) return 1'b0;
        return en_h[v-L] && norst(v - L, v - 1);
    endfunction

    logic [BW-1:0] e_dat;
    logic [D-1:0]  e_vld;
    bit            e_busy;
    bit            e_dd;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_rows[cyc] = rst_h[cyc-1] ? 0 : (exp_rows[cyc-1] + int'(rowvalid(cyc-1))) % 4096;
        end
        if (cyc >= 2) begin
            e_dat = '0;
            e_vld = '0;
            for (int k = 0; k < D; k++) begin
                if (rowvalid(cyc - 1 - k) && norst(cyc - 1 - k, cyc - 1)) begin
                    e_vld[k]         = 1'b1;
                    e_dat[k*W +: W]  = dat_h[cyc-1-k][k*W +: W];
                end
            end
            e_busy = 1'b0;
            for (int v = cyc - D - 1; v <= cyc - 1; v++)
                if (rowvalid(v) && norst(v, cyc - 1)) e_busy = 1'b1;
            e_dd = rowvalid(cyc - D - 1) && norst(cyc - D - 1, cyc);
            for (int u = cyc - D; u <= cyc; u++)
                if (rowvalid(u)) e_dd = 1'b0;

            chk("valid", BW'(array_valid), BW'(e_vld));
            chk("data", array_data, e_dat);
            chk("busy", BW'(busy), BW'(e_busy));
            chk("drain_done", BW'(drain_done), BW'(e_dd));
            chk("rows", BW'(rows_streamed), BW'(exp_rows[cyc]));
            if (drain_done === 1'b1) pulses++;
        end
    end

    task automatic step(input bit e, input bit r);
        @(posedge clk);
        #1;
        cyc++;
        en  = e;
        rst = r;
        for (int k = 0; k < D; k++) din[k*W +: W] = W'($urandom);
        en_h[cyc]  = e;
        rst_h[cyc] = r;
        dat_h[cyc] = din;
    endtask

    task automatic set_din(input logic [BW-1:0] d);
        din        = d;
        dat_h[cyc] = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    int            t0;
    int            p0;
    int            dens;
    logic [BW-1:0] ramp;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle(3);

        // Single row with lane k = k+1.
        step(1'b1, 1'b0);
        t0 = cyc;
        repeat (L) step(1'b0, 1'b0);
        for (int k = 0; k < D; k++) ramp[k*W +: W] = W'(k + 1);
        set_din(ramp);
        for (int k = 0; k < D; k++) begin
            step(1'b0, 1'b0);
            @(negedge clk);
            chk("single_lane_dat", BW'(array_data[k*W +: W]), BW'(k + 1));
            chk("single_lane_vld", BW'(array_valid), BW'(1) << k);
        end
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("single_done_cycle", BW'(cyc - t0), BW'(L + 1 + D));
        chk("single_done", BW'(drain_done), BW'(1));
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("single_busy_low", BW'(busy), BW'(0));
        chk("single_rows", BW'(rows_streamed), BW'(1));

        // 32 rows back-to-back.
        p0 = pulses;
        repeat (32) step(1'b1, 1'b0);
        t0 = cyc - 31;
        while (cyc < t0 + L + D) step(1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_all_valid", BW'(array_valid), BW'({D{1'b1}}));
        idle(D + 5);
        @(negedge clk);
        chk("b2b_rows", BW'(rows_streamed), BW'(33));
        chk("b2b_pulses", BW'(pulses - p0), BW'(1));

        // Gap pattern 1,0,1: lane 5 shows A, 0, B.
        p0 = pulses;
        step(1'b1, 1'b0);
        t0 = cyc;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        while (cyc < t0 + L + 6) step(1'b0, 1'b0);
        @(negedge clk);
        chk("gap_lane5_a", BW'(array_data[5*W +: W]), BW'(dat_h[t0+L][5*W +: W]));
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("gap_lane5_zero", BW'({array_valid[5], array_data[5*W +: W]}), BW'(0));
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("gap_lane5_b", BW'(array_data[5*W +: W]), BW'(dat_h[t0+L+2][5*W +: W]));
        idle(D + 5);
        @(negedge clk);
        chk("gap_pulses", BW'(pulses - p0), BW'(1));
        chk("gap_rows", BW'(rows_streamed), BW'(35));

        // New row lands exactly on the drain_cnt==0 cycle.
        p0 = pulses;
        step(1'b1, 1'b0);
        idle(D);
        step(1'b1, 1'b0);
        repeat (L) step(1'b0, 1'b0);
        @(negedge clk);
        chk("resume_no_pulse", BW'(drain_done), BW'(0));
        chk("resume_busy", BW'(busy), BW'(1));
        idle(D + 5);
        @(negedge clk);
        chk("resume_pulses", BW'(pulses - p0), BW'(1));
        chk("resume_rows", BW'(rows_streamed), BW'(37));

        // Reset in the middle of a 10-cycle read burst.
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i == 5);
            if (i == 6) begin
                @(negedge clk);
                chk("rst_valid", BW'(array_valid), BW'(0));
                chk("rst_data", array_data, BW'(0));
                chk("rst_busy_done", BW'({busy, drain_done}), BW'(0));
                chk("rst_rows", BW'(rows_streamed), BW'(0));
            end
        end
        idle(30);
        @(negedge clk);
        chk("rst_no_pulse", BW'(pulses - p0), BW'(0));
        idle(10);
        @(negedge clk);
        chk("rst_tail_pulse", BW'(pulses - p0), BW'(1));
        chk("rst_tail_rows", BW'(rows_streamed), BW'(4));

        // Randomised traffic with varying density and rare resets.
        dens = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0:       dens = 5;
                    1:       dens = 50;
                    2:       dens = 90;
                    default: dens = 100;
                endcase
            end
            step($urandom_range(0, 99) < dens, $urandom_range(0, 299) == 0);
        end
        idle(D + 5);

        // Row counter wrap.
        step(1'b0, 1'b1);
        p0 = pulses;
        repeat (4097) step(1'b1, 1'b0);
        idle(D + 5);
        @(negedge clk);
        chk("wrap_rows", BW'(rows_streamed), BW'(1));
        chk("wrap_pulses", BW'(pulses - p0), BW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
